// File: rtl/pheap_level_unit_pkg.sv
// pheapTypes: shared types for the pipelined-heap level units.
//   opcode_t : NOP / ENQ / DEQ operation code
//   done_t   : DONE (idle) / BUSY / NEXT_LEVEL (one-cycle forward strobe)
//   entry_t  : heap node {cap = free slots in subtree, pri = priority value}
//   capmax() : free-slot count of an empty subtree rooted at a given level
package pheapTypes;

    localparam int DEF_LEVELS = 4;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ENQ = 2'd1,
        DEQ = 2'd2
    } opcode_t;

    typedef enum logic [1:0] {
        DONE       = 2'd0,
        BUSY       = 2'd1,
        NEXT_LEVEL = 2'd2
    } done_t;

    typedef struct packed {
        logic [15:0] cap;
        logic [31:0] pri;
    } entry_t;

    // 2**(levels-lvl+1)-1; evaluates to 0 one level below the last level,
    // so nothing there ever reads as occupied.
    function automatic logic [15:0] capmax(input int levels, input int lvl);
        return 16'((1 << (levels - lvl + 1)) - 1);
    endfunction

endpackage

// File: rtl/pheap_level_unit_node_mem.sv
// pheap_node_mem: node storage for one heap level.
//   2**(LEVEL-1) entries, async active-low reset to {CAPMAX(LEVEL),0}.
//   clk, rst          : clock / async active-low reset
//   we_i/waddr_i/wdata_i : single write port
//   raddr_i/rdata_o   : own synchronous read port (engine side)
//   paddr_i           : parent-side pair index (ignored when LEVEL==2)
//   pRdL_o/pRdR_o     : registered entries 2*paddr / 2*paddr+1, write-through
module pheap_node_mem
    import pheapTypes::*;
#(
    parameter  int LEVEL  = 2,
    parameter  int LEVELS = DEF_LEVELS,
    localparam int AW     = LEVEL - 1,
    localparam int PAW    = (LEVEL > 2) ? LEVEL - 2 : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  entry_t         wdata_i,
    input  logic [AW-1:0]  raddr_i,
    output entry_t         rdata_o,
    input  logic [PAW-1:0] paddr_i,
    output entry_t         pRdL_o,
    output entry_t         pRdR_o
);

    localparam int     NODES = 2 ** (LEVEL - 1);
    localparam entry_t RST_E = '{cap: capmax(LEVELS, LEVEL), pri: 32'd0};

    entry_t          mem_q [NODES];
    logic [AW-1:0]   idx_l, idx_r;

    if (LEVEL > 2) begin : g_pair
        assign idx_l = {paddr_i, 1'b0};
        assign idx_r = {paddr_i, 1'b1};
    end else begin : g_pair_root
        // Only one pair exists; the parent address is a tied-off stub.
        logic unused_paddr;
        assign unused_paddr = ^paddr_i;
        assign idx_l = AW'(0);
        assign idx_r = AW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NODES; i++) mem_q[i] <= RST_E;
            rdata_o <= RST_E;
            pRdL_o  <= RST_E;
            pRdR_o  <= RST_E;
        end else begin
            if (we_i) mem_q[waddr_i] <= wdata_i;
            rdata_o <= mem_q[raddr_i];
            // Parent sees a same-edge write immediately.
            pRdL_o  <= (we_i && waddr_i == idx_l) ? wdata_i : mem_q[idx_l];
            pRdR_o  <= (we_i && waddr_i == idx_r) ? wdata_i : mem_q[idx_r];
        end
    end

endmodule

// File: rtl/pheap_level_unit.sv
// pheap_level_unit: one P-heap pipeline stage (node storage + ENQ/DEQ engine).
//   clk, rst           : clock / async active-low reset
//   start/op/in/startPos : operation launch (accepted when idle or forwarding)
//   raddrBot, rBotL/R  : child-pair read request to / data from level LEVEL+1
//   paddr, pRdL/pRdR   : parent-side pair read of this level's nodes
//   done               : DONE / BUSY / NEXT_LEVEL strobe
//   out, endPos        : forwarded/removed value and {pos,dir} next-level index
// Optional build macro PHEAP_OVF_FLAG_EN adds output err: one-cycle pulse on
// ENQ overflow or DEQ underflow.
module pheap_level_unit
    import pheapTypes::*;
#(
    parameter  int LEVEL  = 2,
    parameter  int LEVELS = DEF_LEVELS,
    localparam int AW     = LEVEL - 1,
    localparam int PAW    = (LEVEL > 2) ? LEVEL - 2 : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  opcode_t        op,
    input  logic [31:0]    in,
    input  logic [AW-1:0]  startPos,
    output logic [AW-1:0]  raddrBot,
    input  entry_t         rBotL,
    input  entry_t         rBotR,
    input  logic [PAW-1:0] paddr,
    output entry_t         pRdL,
    output entry_t         pRdR,
    output done_t          done,
    output logic [31:0]    out,
    output logic [LEVEL-1:0] endPos
`ifdef PHEAP_OVF_FLAG_EN
   ,output logic           err
`endif
);

    localparam logic [15:0] CAP_SELF  = capmax(LEVELS, LEVEL);
    localparam logic [15:0] CAP_CHILD = capmax(LEVELS, LEVEL + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_FWD} state_t;

    state_t          state_q;
    done_t           done_q;
    opcode_t         op_q;
    logic [31:0]     val_q, out_q;
    logic [AW-1:0]   pos_q, raddr_q;
    logic [LEVEL-1:0] endpos_q;

    entry_t          node;
    entry_t          wdata_d;
    logic            we_d, fwd_d, upd_d, dir_d, flag_d;
    logic [31:0]     out_d;
    logic            occ, l_occ, r_occ;

    pheap_node_mem #(.LEVEL(LEVEL), .LEVELS(LEVELS)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_d && state_q == S_EXEC),
        .waddr_i (pos_q),
        .wdata_i (wdata_d),
        .raddr_i (pos_q),
        .rdata_o (node),
        .paddr_i (paddr),
        .pRdL_o  (pRdL),
        .pRdR_o  (pRdR)
    );

    assign occ   = node.cap < CAP_SELF;
    assign l_occ = (LEVEL < LEVELS) && (rBotL.cap < CAP_CHILD);
    assign r_occ = (LEVEL < LEVELS) && (rBotR.cap < CAP_CHILD);

    // EXEC-cycle decision; only takes effect while state_q == S_EXEC.
    always_comb begin
        we_d    = 1'b0;
        wdata_d = node;
        fwd_d   = 1'b0;
        upd_d   = 1'b0;
        dir_d   = 1'b0;
        flag_d  = 1'b0;
        out_d   = out_q;
        case (op_q)
            ENQ: begin
                if (node.cap == 16'd0) begin
                    flag_d = 1'b1;
                end else if (!occ) begin
                    we_d    = 1'b1;
                    wdata_d = '{cap: node.cap - 16'd1, pri: val_q};
                end else begin
                    // Keep the larger value here, push the smaller one down
                    // into the subtree with more room.
                    we_d    = 1'b1;
                    upd_d   = 1'b1;
                    fwd_d   = 1'b1;
                    wdata_d = '{cap: node.cap - 16'd1,
                                pri: (val_q > node.pri) ? val_q : node.pri};
                    out_d   = (val_q > node.pri) ? node.pri : val_q;
                    dir_d   = rBotR.cap > rBotL.cap;
                end
            end
            DEQ: begin
                if (!occ) begin
                    flag_d = 1'b1;
                end else if (!l_occ && !r_occ) begin
                    we_d    = 1'b1;
                    upd_d   = 1'b1;
                    wdata_d = '{cap: node.cap + 16'd1, pri: 32'd0};
                    out_d   = node.pri;
                end else begin
                    // Promote the larger occupied child; the hole moves down.
                    we_d    = 1'b1;
                    upd_d   = 1'b1;
                    fwd_d   = 1'b1;
                    dir_d   = r_occ && (!l_occ || rBotR.pri > rBotL.pri);
                    wdata_d = '{cap: node.cap + 16'd1,
                                pri: dir_d ? rBotR.pri : rBotL.pri};
                    out_d   = node.pri;
                end
            end
            default: ;
        endcase
    end

`ifdef PHEAP_OVF_FLAG_EN
    logic err_q;
    assign err = err_q;
`else
    logic unused_flag;
    assign unused_flag = flag_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            done_q   <= DONE;
            op_q     <= NOP;
            val_q    <= '0;
            pos_q    <= '0;
            raddr_q  <= '0;
            out_q    <= '0;
            endpos_q <= '0;
`ifdef PHEAP_OVF_FLAG_EN
            err_q    <= 1'b0;
`endif
        end else begin
`ifdef PHEAP_OVF_FLAG_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE, S_FWD: begin
                    state_q <= S_IDLE;
                    done_q  <= DONE;
                    if (start) begin
                        state_q <= S_READ;
                        done_q  <= BUSY;
                        op_q    <= op;
                        val_q   <= in;
                        pos_q   <= startPos;
                        raddr_q <= startPos;
                    end
                end
                S_READ: begin
                    state_q <= S_EXEC;
                    done_q  <= BUSY;
                end
                S_EXEC: begin
                    state_q <= fwd_d ? S_FWD : S_IDLE;
                    done_q  <= fwd_d ? NEXT_LEVEL : DONE;
                    if (upd_d) begin
                        out_q    <= out_d;
                        endpos_q <= {pos_q, dir_d};
                    end
`ifdef PHEAP_OVF_FLAG_EN
                    err_q <= flag_d;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= DONE;
                end
            endcase
        end
    end

    assign done     = done_q;
    assign out      = out_q;
    assign endPos   = endpos_q;
    assign raddrBot = raddr_q;

endmodule

// File: tb/tb_pheap_level_unit.sv
// Directed bench for pheap_level_unit with LEVELS=3, LEVEL=2
// (CAPMAX(2)=3, child CAPMAX=1). Inputs driven on the falling edge,
// outputs sampled on the falling edge.
module tb_pheap_level_unit;
    import pheapTypes::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    opcode_t     op = NOP;
    logic [31:0] in_v = '0;
    logic [0:0]  startPos = '0;
    logic [0:0]  raddrBot;
    entry_t      rBotL = '0;
    entry_t      rBotR = '0;
    logic [0:0]  paddr = '0;
    entry_t      pRdL, pRdR;
    done_t       done;
    logic [31:0] out_v;
    logic [1:0]  endPos;
`ifdef PHEAP_OVF_FLAG_EN
    logic        err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pheap_level_unit #(.LEVEL(2), .LEVELS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .in       (in_v),
        .startPos (startPos),
        .raddrBot (raddrBot),
        .rBotL    (rBotL),
        .rBotR    (rBotR),
        .paddr    (paddr),
        .pRdL     (pRdL),
        .pRdR     (pRdR),
        .done     (done),
        .out      (out_v),
        .endPos   (endPos)
`ifdef PHEAP_OVF_FLAG_EN
       ,.err      (err)
`endif
    );

    function automatic entry_t E(input int c, input int p);
        return '{cap: 16'(c), pri: 32'(p)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the
    // EXEC-end edge, where the final done value is checked.
    task automatic op_run(input opcode_t o, input int v, input int p,
                          input entry_t l, input entry_t r,
                          input done_t fin, input string tag);
        start = 1'b1; op = o; in_v = 32'(v); startPos = 1'(p);
        rBotL = l; rBotR = r;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy0"}, 64'(done), 64'(BUSY));
        chk({tag, ".raddr"}, 64'(raddrBot), 64'(p));
        @(negedge clk);
        chk({tag, ".busy1"}, 64'(done), 64'(BUSY));
        @(negedge clk);
        chk({tag, ".fin"}, 64'(done), 64'(fin));
    endtask

    initial begin
        // 1: reset state
        repeat (2) @(negedge clk);
        chk("rst.done", 64'(done), 64'(DONE));
        chk("rst.pL", 64'(pRdL), 64'(E(3, 0)));
        chk("rst.pR", 64'(pRdR), 64'(E(3, 0)));
        chk("rst.out", 64'(out_v), 64'd0);
        chk("rst.endpos", 64'(endPos), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst.done", 64'(done), 64'(DONE));

        // 2: ENQ into empty node, no forward
        op_run(ENQ, 50, 0, E(1, 0), E(1, 0), DONE, "enq50");
        chk("enq50.node0", 64'(pRdL), 64'(E(2, 50)));

        // 3: ENQ pushes the smaller value down-left
        op_run(ENQ, 70, 0, E(1, 0), E(1, 0), NEXT_LEVEL, "enq70");
        chk("enq70.node0", 64'(pRdL), 64'(E(1, 70)));
        chk("enq70.out", 64'(out_v), 64'd50);
        chk("enq70.endpos", 64'(endPos), 64'b00);
        @(negedge clk);
        chk("enq70.strobe1", 64'(done), 64'(DONE));

        // 4: right child has more room
        op_run(ENQ, 40, 1, E(1, 0), E(1, 0), DONE, "enq40");
        chk("enq40.node1", 64'(pRdR), 64'(E(2, 40)));
        op_run(ENQ, 10, 1, E(0, 0), E(1, 0), NEXT_LEVEL, "enq10");
        chk("enq10.node1", 64'(pRdR), 64'(E(1, 40)));
        chk("enq10.out", 64'(out_v), 64'd10);
        chk("enq10.endpos", 64'(endPos), 64'b11);
        @(negedge clk);

        // 5: DEQ promotes the only occupied (left) child
        op_run(DEQ, 0, 0, E(0, 50), E(1, 0), NEXT_LEVEL, "deq0");
        chk("deq0.node0", 64'(pRdL), 64'(E(2, 50)));
        chk("deq0.out", 64'(out_v), 64'd70);
        chk("deq0.endpos", 64'(endPos), 64'b00);
        @(negedge clk);

        // DEQ with no occupied child empties the node in place
        op_run(DEQ, 0, 1, E(1, 0), E(1, 0), DONE, "deqleaf");
        chk("deqleaf.node1", 64'(pRdR), 64'(E(2, 0)));
`ifdef PHEAP_OVF_FLAG_EN
        chk("deqleaf.err", 64'(err), 64'd0);
`endif

        // reset while BUSY aborts and reinitialises nodes
        start = 1'b1; op = ENQ; in_v = 32'd99; startPos = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("rstmid.busy", 64'(done), 64'(BUSY));
        rst = 1'b0;
        #1;
        chk("rstmid.done", 64'(done), 64'(DONE));
        chk("rstmid.pL", 64'(pRdL), 64'(E(3, 0)));
        chk("rstmid.pR", 64'(pRdR), 64'(E(3, 0)));
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid.idle", 64'(done), 64'(DONE));
        chk("rstmid.node0", 64'(pRdL), 64'(E(3, 0)));

        // 6: underflow on an empty node
        op_run(DEQ, 0, 1, E(1, 0), E(1, 0), DONE, "underflow");
        chk("underflow.node1", 64'(pRdR), 64'(E(3, 0)));
`ifdef PHEAP_OVF_FLAG_EN
        chk("underflow.err", 64'(err), 64'd1);
`endif

        // fill node0 to cap 0 with a back-to-back forward, then overflow
        op_run(ENQ, 5, 0, E(1, 0), E(1, 0), DONE, "fill5");
        op_run(ENQ, 6, 0, E(1, 0), E(1, 0), NEXT_LEVEL, "fill6");
        chk("fill6.out", 64'(out_v), 64'd5);
        op_run(ENQ, 7, 0, E(1, 0), E(1, 0), NEXT_LEVEL, "fill7");
        chk("fill7.node0", 64'(pRdL), 64'(E(0, 7)));
        chk("fill7.out", 64'(out_v), 64'd6);
        chk("fill7.endpos", 64'(endPos), 64'b00);
        op_run(ENQ, 8, 0, E(1, 0), E(1, 0), DONE, "overflow");
        chk("overflow.node0", 64'(pRdL), 64'(E(0, 7)));
`ifdef PHEAP_OVF_FLAG_EN
        chk("overflow.err", 64'(err), 64'd1);
`endif
        @(negedge clk);
        chk("end.done", 64'(done), 64'(DONE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
